// File: rtl/zigzag_pkg.sv
// Shared definitions for the zigzag word unpacker: FSM state encoding,
// default token values, word geometry and the character-count width helper.
// The optional pad-skip behaviour is selected with ZIGZAG_UNPACK_SKIP_PAD_EN
// inside zigzag_byte_selector; nothing in this package depends on it.
package zigzag_pkg;

  // Unpacker control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  // End-of-message / start-decryption marker
  localparam logic [7:0] START_TOKEN_DEFAULT = 8'hFA;

  // Filler byte, only meaningful when pad skipping is compiled in
  localparam logic [7:0] PAD_TOKEN_DEFAULT = 8'h00;

  // Characters packed into one input word, character 0 in the MSB byte
  localparam int CHARS_PER_WORD = 4;

  // Width of the byte index inside a word
  localparam int IDX_W = $clog2(CHARS_PER_WORD);

  // Bits needed to hold a character count from 0 up to max_chars inclusive
  function automatic int count_width(input int max_chars);
    if (max_chars < 1) begin
      return 1;
    end else begin
      return $clog2(max_chars + 1);
    end
  endfunction

endpackage

// File: rtl/zigzag_byte_selector.sv
// Combinational byte picker for the zigzag word unpacker.
// Given the latched word and the current byte index it returns the byte to
// emit, the index it came from, whether no emittable byte is left at or after
// the index, and whether the selected byte is the last emittable one.
// With ZIGZAG_UNPACK_SKIP_PAD_EN defined, bytes equal to PAD_TOKEN are jumped
// over; otherwise every byte is emittable and the selection is simply the
// current index.
module zigzag_byte_selector
  import zigzag_pkg::*;
#(
  parameter int                 D_WIDTH   = 8,
  parameter logic [D_WIDTH-1:0] PAD_TOKEN = D_WIDTH'(PAD_TOKEN_DEFAULT)
) (
  input  logic [CHARS_PER_WORD*D_WIDTH-1:0] i_word,
  input  logic [IDX_W-1:0]                  i_index,
  output logic [D_WIDTH-1:0]                o_byte,
  output logic [IDX_W-1:0]                  o_sel_idx,
  output logic                              o_none_left,
  output logic                              o_last
);

`ifdef ZIGZAG_UNPACK_SKIP_PAD_EN
  localparam bit SKIP_PAD_EN = 1'b1;
`else
  localparam bit SKIP_PAD_EN = 1'b0;
`endif

  localparam int WORD_W = CHARS_PER_WORD * D_WIDTH;

  logic             w_found;
  logic             w_more;
  logic [IDX_W-1:0] w_sel;

  // Character idx of the word; character 0 sits in the most significant byte
  function automatic logic [D_WIDTH-1:0] byte_at(input logic [WORD_W-1:0] word,
                                                 input int idx);
    return word[(CHARS_PER_WORD - 1 - idx) * D_WIDTH +: D_WIDTH];
  endfunction

  // A byte is skipped only when pad skipping is built in and it is a pad
  function automatic logic is_skipped(input logic [D_WIDTH-1:0] b);
    return SKIP_PAD_EN && (b == PAD_TOKEN);
  endfunction

  // Scan forward from the current index for the first and any further emittable byte
  always_comb begin
    w_found = 1'b0;
    w_more  = 1'b0;
    w_sel   = i_index;
    for (int k = 0; k < CHARS_PER_WORD; k++) begin
      if ((k >= int'(i_index)) && !is_skipped(byte_at(i_word, k))) begin
        if (!w_found) begin
          w_found = 1'b1;
          w_sel   = IDX_W'(k);
        end else begin
          w_more = 1'b1;
        end
      end else begin
        w_more = w_more;
      end
    end
    o_sel_idx   = w_sel;
    o_none_left = !w_found;
    o_last      = !w_more;
    o_byte      = byte_at(i_word, int'(w_sel));
  end

endmodule

// File: rtl/zigzag_word_unpacker.sv
// Zigzag word unpacker: accepts packed 4-character words and serialises them
// into the decryptor's one-character-per-cycle data/valid stream.
// - A START_DECRYPTION_TOKEN byte ends the message: the rest of its word is
//   dropped and the block waits for the decryptor's busy high/low handshake.
// - After MAX_NOF_CHARS characters the next ordinary byte is replaced by the
//   token, forcing a message boundary.
// - busy_i high during SHIFT freezes the stream at the current byte.
// All outputs are registered. Optional build macro: ZIGZAG_UNPACK_SKIP_PAD_EN
// (drop PAD_TOKEN bytes without emitting, counting or spending a cycle).
module zigzag_word_unpacker
  import zigzag_pkg::*;
#(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(START_TOKEN_DEFAULT),
  parameter logic [D_WIDTH-1:0] PAD_TOKEN              = D_WIDTH'(PAD_TOKEN_DEFAULT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CHARS_PER_WORD*D_WIDTH-1:0] data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic                              busy_i,
  output logic [D_WIDTH-1:0]                data_o,
  output logic                              valid_o
);

  localparam int               WORD_W  = CHARS_PER_WORD * D_WIDTH;
  localparam int               CNT_W   = count_width(MAX_NOF_CHARS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NOF_CHARS);

  // Registered state
  state_e             r_state;
  logic [WORD_W-1:0]  r_word;
  logic [IDX_W-1:0]   r_index;
  logic [CNT_W-1:0]   r_count;
  logic [D_WIDTH-1:0] r_data;
  logic               r_valid;
  logic               r_ready;

  // Next-state values
  state_e             w_state_nxt;
  logic [WORD_W-1:0]  w_word_nxt;
  logic [IDX_W-1:0]   w_index_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [D_WIDTH-1:0] w_data_nxt;
  logic               w_valid_nxt;
  logic               w_ready_nxt;

  // Byte selector results for the current word/index
  logic [D_WIDTH-1:0] w_sel_byte;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_none_left;
  logic               w_last;

  zigzag_byte_selector #(
    .D_WIDTH   (D_WIDTH),
    .PAD_TOKEN (PAD_TOKEN)
  ) u_byte_selector (
    .i_word      (r_word),
    .i_index     (r_index),
    .o_byte      (w_sel_byte),
    .o_sel_idx   (w_sel_idx),
    .o_none_left (w_none_left),
    .o_last      (w_last)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_index_nxt = r_index;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        // r_ready is still low on the very first cycle out of reset
        if (valid_i && r_ready) begin
          w_word_nxt  = data_i;
          w_index_nxt = {IDX_W{1'b0}};
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (busy_i) begin
          // Decryptor stalled us: keep word and index, emit nothing
          w_state_nxt = SHIFT;
        end else if (w_none_left) begin
          // Only pads remained in the word
          w_state_nxt = IDLE;
        end else if ((w_sel_byte == START_DECRYPTION_TOKEN) || (r_count == CNT_MAX)) begin
          // Real or forced end of message; the rest of the word is dropped
          w_data_nxt  = START_DECRYPTION_TOKEN;
          w_valid_nxt = 1'b1;
          w_count_nxt = {CNT_W{1'b0}};
          w_state_nxt = WAIT_HI;
        end else begin
          w_data_nxt  = w_sel_byte;
          w_valid_nxt = 1'b1;
          w_count_nxt = r_count + CNT_W'(1);
          w_index_nxt = w_sel_idx + IDX_W'(1);
          w_state_nxt = w_last ? IDLE : SHIFT;
        end
      end
      WAIT_HI: begin
        // The decryptor may take a cycle or more to raise busy
        if (busy_i) begin
          w_state_nxt = WAIT_LO;
        end else begin
          w_state_nxt = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!busy_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_LO;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // ready_o mirrors "in IDLE" one register stage ahead, so it appears
    // together with the last beat of a word
    w_ready_nxt = (w_state_nxt == IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= {WORD_W{1'b0}};
      r_index <= {IDX_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_data  <= {D_WIDTH{1'b0}};
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_word  <= w_word_nxt;
      r_index <= w_index_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign ready_o = r_ready;

endmodule
